// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Writeback arbiter between the functional units and the single scalar
//   register-file writeback port. Each unit parks one completed result in a
//   private holding slot. A round-robin arbiter drains one slot per cycle
//   into a registered writeback stage. Speculative results are dropped on
//   flush, and nothing drains while frozen.
//
// Ports
//   CLK        clock, rising edge
//   nRST       synchronous active-low reset
//   req_valid  per-unit result valid
//   req_ready  per-unit accept (transfer = valid & ready at the edge)
//   req_rd     per-unit destination register, unit i at [i*REG_W +: REG_W]
//   req_data   per-unit result data, unit i at [i*DATA_W +: DATA_W]
//   req_spec   per-unit speculative flag
//   flush      drop all speculative slots and speculative incoming results
//   freeze     no grants; full slots hold, empty slots still accept
//   wb_valid   registered writeback valid
//   wb_rd      registered writeback destination
//   wb_data    registered writeback data
//   wb_src     registered index of the granted unit
//   busy       any holding slot occupied
module wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*REG_W-1:0]    req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_spec,
  input  logic                        flush,
  input  logic                        freeze,
  output logic                        wb_valid,
  output logic [REG_W-1:0]            wb_rd,
  output logic [DATA_W-1:0]           wb_data,
  output logic [SRC_W-1:0]            wb_src,
  output logic                        busy
);

  logic [NUM_REQ-1:0]              full_q, full_d;
  logic [NUM_REQ-1:0]              spec_q, spec_d;
  logic [NUM_REQ-1:0][REG_W-1:0]   rd_q, rd_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_q, data_d;
  logic [SRC_W-1:0]                ptr_q, ptr_d;

  logic                            wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]                wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]               wb_data_q, wb_data_d;
  logic [SRC_W-1:0]                wb_src_q, wb_src_d;

  logic [NUM_REQ-1:0]              eligible;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              accept;
  logic                            any_grant;
  logic [SRC_W-1:0]                grant_idx;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin : arbitrate
    int idx;
    idx       = 0;
    eligible  = full_q & ~{NUM_REQ{freeze}} & ~({NUM_REQ{flush}} & spec_q);
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_grant && eligible[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SRC_W'(idx);
      end
    end
  end

  // A slot being drained this cycle can take a new result in the same edge.
  assign req_ready = ~full_q | (grant & ~{NUM_REQ{freeze}});
  assign accept    = req_valid & req_ready;

  always_comb begin : slot_next
    full_d = full_q;
    spec_d = spec_q;
    rd_d   = rd_q;
    data_d = data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] || (flush && spec_q[i])) begin
        full_d[i] = 1'b0;
        spec_d[i] = 1'b0;
      end
      // rd 0 is a sink: the transfer completes but nothing is held.
      // Speculative arrivals during a flush are swallowed the same way.
      if (accept[i] && (req_rd[i*REG_W +: REG_W] != '0) && !(flush && req_spec[i])) begin
        full_d[i] = 1'b1;
        spec_d[i] = req_spec[i];
        rd_d[i]   = req_rd[i*REG_W +: REG_W];
        data_d[i] = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : wb_next
    ptr_d      = ptr_q;
    wb_valid_d = any_grant;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_src_d   = wb_src_q;
    if (any_grant) begin
      ptr_d     = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      wb_rd_d   = rd_q[grant_idx];
      wb_data_d = data_q[grant_idx];
      wb_src_d  = grant_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full_q     <= '0;
      spec_q     <= '0;
      rd_q       <= '0;
      data_q     <= '0;
      ptr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else begin
      full_q     <= full_d;
      spec_q     <= spec_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      ptr_q      <= ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_src   = wb_src_q;
  assign busy     = |full_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a slot-level reference model.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 2;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*RW-1:0]  req_rd;
  logic [N*DW-1:0]  req_data;
  logic [N-1:0]     req_spec;
  logic             flush;
  logic             freeze;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic [SW-1:0]    wb_src;
  logic             busy;

  wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .REG_W(RW)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd   (req_rd),
    .req_data (req_data),
    .req_spec (req_spec),
    .flush    (flush),
    .freeze   (freeze),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_src   (wb_src),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one record per holding slot, plus the round-robin
  // pointer and the registered writeback fields.
  bit            m_full [N];
  bit            m_spec [N];
  logic [RW-1:0] m_rd   [N];
  logic [DW-1:0] m_data [N];
  int            m_ptr;
  bit            m_wbv;
  logic [RW-1:0] m_wbrd;
  logic [DW-1:0] m_wbdata;
  int            m_wbsrc;
  int            waits  [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_spec[i] = 0; m_rd[i] = '0; m_data[i] = '0; waits[i] = 0;
    end
    m_ptr = 0; m_wbv = 0; m_wbrd = '0; m_wbdata = '0; m_wbsrc = 0;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_rd = '0; req_data = '0; req_spec = '0;
    flush = 0; freeze = 0;
  endtask

  task automatic set_req(input int i, input bit v, input int rd, input logic [DW-1:0] d, input bit s);
    req_valid[i]         = v;
    req_rd[i*RW +: RW]   = RW'(rd);
    req_data[i*DW +: DW] = d;
    req_spec[i]          = s;
  endtask

  // Inputs are set by the caller after a falling edge; this compares the
  // DUT against the model, advances the model across the rising edge and
  // returns just after the next falling edge.
  task automatic step();
    int win;
    logic [N-1:0] exp_ready;
    #1;
    win = -1;
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (win < 0 && m_full[k] && !freeze && !(flush && m_spec[k])) win = k;
    end
    for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i] || (win == i);
    chk("req_ready", req_ready, exp_ready);
    chk("wb_valid",  wb_valid,  m_wbv);
    chk("wb_rd",     wb_rd,     m_wbrd);
    chk("wb_data",   wb_data,   m_wbdata);
    chk("wb_src",    wb_src,    m_wbsrc);
    chk("busy",      busy,      (m_full[0] | m_full[1] | m_full[2] | m_full[3]));
    if (nRST) begin
      for (int i = 0; i < N; i++) begin
        if (m_full[i] && win != i && !freeze && !(flush && m_spec[i])) begin
          waits[i]++;
          chk("fairness", waits[i] < N, 1);
        end
      end
    end
    if (!nRST) begin
      model_reset();
    end else begin
      if (win >= 0) begin
        m_wbv = 1; m_wbrd = m_rd[win]; m_wbdata = m_data[win]; m_wbsrc = win;
        m_ptr = (win + 1) % N;
      end else begin
        m_wbv = 0;
      end
      for (int i = 0; i < N; i++) begin
        bit acc;
        acc = req_valid[i] && exp_ready[i];
        if (win == i || (flush && m_spec[i])) begin
          m_full[i] = 0; waits[i] = 0;
        end
        if (acc && req_rd[i*RW +: RW] != '0 && !(flush && req_spec[i])) begin
          m_full[i] = 1; m_spec[i] = req_spec[i];
          m_rd[i] = req_rd[i*RW +: RW]; m_data[i] = req_data[i*DW +: DW];
          waits[i] = 0;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    clear_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    model_reset();
    nRST = 1;

    // Reset state: everything idle, all units ready.
    step();

    // Single request through unit 2.
    set_req(2, 1, 7, 32'hDEADBEEF, 0);
    step();
    clear_inputs();
    step();
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_rd",    wb_rd,    7);
    chk("t1_wb_data",  wb_data,  32'hDEADBEEF);
    chk("t1_wb_src",   wb_src,   2);
    step();
    chk("t1_busy", busy, 0);

    // Mid-run reset to bring ptr back to 0, then all units reload every cycle.
    nRST = 0;
    step();
    nRST = 1;
    for (int s = 1; s <= 10; s++) begin
      for (int i = 0; i < N; i++) set_req(i, 1, 10 + i, $urandom, 0);
      step();
      if (s >= 2) begin
        chk("rr_wb_valid", wb_valid, 1);
        chk("rr_wb_src",   wb_src,   (s - 2) % N);
        chk("rr_wb_rd",    wb_rd,    10 + (s - 2) % N);
      end
    end
    clear_inputs();
    repeat (5) step();

    // Flush drops speculative slots 0 and 1; only unit 3 writes back.
    freeze = 1;
    set_req(0, 1, 3, 32'h1111_0000, 1);
    set_req(1, 1, 4, 32'h2222_0000, 1);
    set_req(3, 1, 5, 32'h3333_0000, 0);
    step();
    clear_inputs();
    flush = 1;
    step();
    flush = 0;
    chk("fl_wb_valid", wb_valid, 1);
    chk("fl_wb_src",   wb_src,   3);
    chk("fl_wb_rd",    wb_rd,    5);
    step();
    chk("fl_idle_valid", wb_valid, 0);
    chk("fl_idle_busy",  busy,     0);

    // Freeze with all slots full: nothing drains and nobody is ready.
    freeze = 1;
    for (int i = 0; i < N; i++) set_req(i, 1, 20 + i, 32'hA000_0000 + i, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 1, 28, $urandom, 0);
      step();
      chk("fz_wb_valid",  wb_valid,  0);
      chk("fz_req_ready", req_ready, 4'b0000);
    end
    clear_inputs();
    for (int c = 0; c < N; c++) begin
      step();
      chk("fz_drain_src", wb_src, c);
      chk("fz_drain_rd",  wb_rd,  20 + c);
    end
    step();

    // rd 0 is accepted but never held or written back.
    set_req(1, 1, 0, 32'hBAD0_0000, 0);
    #1;
    chk("rd0_ready", req_ready[1], 1);
    step();
    clear_inputs();
    step();
    chk("rd0_wb_valid", wb_valid, 0);
    chk("rd0_busy",     busy,     0);

    // Reset while three slots are full and a writeback is in flight.
    freeze = 1;
    set_req(0, 1, 9, 32'h0000_0009, 0);
    set_req(2, 1, 10, 32'h0000_000A, 0);
    set_req(3, 1, 11, 32'h0000_000B, 0);
    step();
    clear_inputs();
    step();
    chk("rst_pre_valid", wb_valid, 1);
    nRST = 0;
    step();
    nRST = 1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_busy",     busy,     0);
    set_req(1, 1, 12, 32'h0000_000C, 0);
    set_req(3, 1, 13, 32'h0000_000D, 0);
    step();
    clear_inputs();
    step();
    chk("rst_first_src", wb_src, 1);
    repeat (3) step();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        int rd;
        rd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
        set_req(i, $urandom_range(0, 2) != 0, rd, $urandom, $urandom_range(0, 2) == 0);
      end
      flush  = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      nRST   = ($urandom_range(0, 149) != 0);
      step();
    end
    clear_inputs();
    nRST = 1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the scoreboard's functional units and the single scalar register-file writeback port. Up to NUM_REQ units (scalar ALU, branch, scalar load/store, matrix load/store) each park one completed result in a private holding register. A round-robin arbiter drains one result per cycle into a registered writeback stage, which feeds the scoreboard's `wb` input. Speculative results are dropped on flush, and nothing drains while frozen.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8)
- DATA_W, 32, result width
- REG_W, 5, destination register index width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-unit result valid
- req_ready  out  NUM_REQ  per-unit accept; a transfer occurs when valid & ready at the edge
- req_rd  in  NUM_REQ*REG_W  per-unit destination register (unit i at bits [i*REG_W +: REG_W])
- req_data  in  NUM_REQ*DATA_W  per-unit result data
- req_spec  in  NUM_REQ  result belongs to a speculative (post-branch) instruction
- flush  in  1  discard all speculative state
- freeze  in  1  stall: no grants, no new acceptances into full slots
- wb_valid  out  1  writeback valid (registered)
- wb_rd  out  REG_W  writeback destination
- wb_data  out  DATA_W  writeback data
- wb_src  out  clog2(NUM_REQ)  index of the granted unit
- busy  out  1  any holding register occupied

## Operation
- Per unit i, the holding register contains {full, spec, rd, data}.
- req_ready[i] = ~full[i] | (grant[i] & ~freeze).
  - Accept with a same-cycle grant in the same slot is allowed: old entry drains, new entry loads.
- Accepting a result with rd == 0 consumes the transfer but leaves the slot unchanged; rd 0 never appears on wb.
- Arbitration is combinational over eligible slots. Slot i is eligible when full[i] & ~freeze & ~(flush & spec[i]).
  - Search starts at the pointer ptr and wraps modulo NUM_REQ; the first eligible slot wins.
  - At most one grant per cycle.
- On a grant to slot k:
  - ptr <= (k+1) mod NUM_REQ.
  - Slot k clears unless reloaded the same cycle.
  - ptr is unchanged when there is no grant.
- Writeback stage, registered every cycle:
  - wb_valid <= any_grant.
  - wb_rd, wb_data and wb_src <= the granted slot's fields.
  - With no grant, the data fields hold their previous values.
- Flush:
  - All full slots with spec=1 clear at the edge.
  - Incoming transfers with req_spec=1 in the flush cycle are accepted and discarded.
  - Non-speculative slots and incoming non-speculative results are unaffected.
  - A grant already registered in the wb stage is not retracted.
- Freeze:
  - No grants, so wb_valid=0 in the following cycle.
  - Empty slots still accept; full slots hold; ptr holds.
- flush & freeze together: flush clearing applies and no grants occur.
- Fairness: a continuously full slot is granted within NUM_REQ cycles of becoming full, absent freeze.
- busy = OR of the full bits.

## Timing
- Reset (nRST low at an edge):
  - All full and spec bits 0.
  - ptr = 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0, wb_src = 0.
  - busy = 0.
  - req_ready is all ones the cycle after reset.
- Reset mid-operation discards every held result; there is no partial drain.
- Latency:
  - Transfer at edge N loads the slot.
  - Earliest grant is in cycle N+1.
  - wb_valid is high in cycle N+2, i.e. 2 cycles.
  - There is no combinational path from req_* to wb_*.
- Throughput: 1 writeback per cycle when any slot is eligible.
- Full boundary: with all slots full and no grant possible (freeze), req_ready = 0 on every unit.
- Empty boundary: with no slot eligible, wb_valid deasserts the next cycle.
- Pointer wrap: a grant to slot NUM_REQ-1 sets ptr = 0.

## Test plan
- Reset, then a single request with unit 2, rd=7, data=0xDEADBEEF, spec=0 at edge 1 -> wb_valid=1, wb_rd=7, wb_data=0xDEADBEEF, wb_src=2 in cycle 3; busy=0 afterward.
- All 4 units present a result in the same cycle with ptr=0, then each reloads every cycle with rd = 10+i -> wb_src sequence 0,1,2,3,0,1..., one per cycle, and no unit is ever skipped.
- Units 0 and 1 hold spec=1 and unit 3 holds spec=0, then flush is pulsed -> slots 0 and 1 cleared, only wb_src=3 is written back, and ptr stays consistent with that grant.
- freeze held for 3 cycles with all slots full -> wb_valid=0 for those 3 cycles and req_ready=4'b0000; after freeze drops, the results drain in round-robin order starting at the saved ptr.
- Unit 1 sends rd=0 -> req_ready=1, no wb_valid, busy stays 0.
- nRST asserted while 3 slots are full and wb_valid=1 -> next cycle wb_valid=0, busy=0, and after release the first grant goes to the lowest eligible index.
